// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types, requester ids and sizing helper for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_NN  = 1'b1;

  function automatic int beat_cnt_width(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/dmem_rd_tracker.sv
// rtl/dmem_rd_tracker.sv - fixed-latency {valid,id} pipeline steering read returns to their requester
module dmem_rd_tracker
  import dmem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic rd_beat,
  input  logic rd_id,
  output logic rvalid0,
  output logic rvalid1
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [READ_LATENCY-1:0] id_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= rd_beat;
      id_q[0]  <= rd_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  // Masked during reset so a read issued just before RST never reports back.
  assign rvalid0 = !RST && vld_q[READ_LATENCY-1] && (id_q[READ_LATENCY-1] == REQ_CPU);
  assign rvalid1 = !RST && vld_q[READ_LATENCY-1] && (id_q[READ_LATENCY-1] == REQ_NN);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin, burst-bounded arbiter for the single-port data memory
// Defining DMEM_ARB_STATS_EN adds per-port beat counters and a conflict counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int IN_BUS_WIDTH = 32,
  parameter int MEMORY_WIDTH = 32,
  parameter int BURST_MAX    = 4,
  parameter int READ_LATENCY = 1
`ifdef DMEM_ARB_STATS_EN
  ,
  parameter int STAT_WIDTH   = 16
`endif
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req0,
  input  logic                    we0,
  input  logic [IN_BUS_WIDTH-1:0] addr0,
  input  logic [MEMORY_WIDTH-1:0] wdata0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [IN_BUS_WIDTH-1:0] addr1,
  input  logic [MEMORY_WIDTH-1:0] wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    mem_writeEn,
  output logic                    mem_readEn,
  output logic [IN_BUS_WIDTH-1:0] mem_addr,
  output logic [MEMORY_WIDTH-1:0] mem_wdata,
  input  logic [MEMORY_WIDTH-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]   stat_gnt0,
  output logic [STAT_WIDTH-1:0]   stat_gnt1,
  output logic [STAT_WIDTH-1:0]   stat_conflict
`endif
);

  localparam int            CW       = beat_cnt_width(BURST_MAX);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic own_req, oth_req, sel_we, beat;

  assign own_req = (owner_q == REQ_NN) ? req1 : req0;
  assign oth_req = (owner_q == REQ_NN) ? req0 : req1;
  assign sel_we  = (owner_q == REQ_NN) ? we1  : we0;

  assign gnt0 = !RST && (state_q == OWN) && (owner_q == REQ_CPU) && req0;
  assign gnt1 = !RST && (state_q == OWN) && (owner_q == REQ_NN)  && req1;
  assign beat = gnt0 || gnt1;

  assign mem_writeEn = beat && sel_we;
  assign mem_readEn  = beat && !sel_we;
  assign mem_addr    = (owner_q == REQ_NN) ? addr1  : addr0;
  assign mem_wdata   = (owner_q == REQ_NN) ? wdata1 : wdata0;
  assign rdata       = mem_rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= REQ_CPU;
      prio_q  <= REQ_CPU;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
          state_d = OWN;
          owner_d = prio_q;
          prio_d  = !prio_q;
        end else if (req0) begin
          state_d = OWN;
          owner_d = REQ_CPU;
          prio_d  = REQ_NN;
        end else if (req1) begin
          state_d = OWN;
          owner_d = REQ_NN;
          prio_d  = REQ_CPU;
        end
      end
      OWN: begin
        if (beat && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // >= rather than == so a saturated long-running owner still yields on its next beat.
        if (!own_req || (cnt_q >= CNT_LAST && oth_req)) begin
          cnt_d = '0;
          if (oth_req) begin
            owner_d = !owner_q;
            prio_d  = owner_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_rd_tracker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_tracker (
    .CLK     (CLK),
    .RST     (RST),
    .rd_beat (mem_readEn),
    .rd_id   (owner_q),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1)
  );

`ifdef DMEM_ARB_STATS_EN
  logic conflict;
  assign conflict = (req0 && req1 && !beat) || (beat && oth_req);

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt0 && stat_gnt0 != '1) stat_gnt0 <= stat_gnt0 + 1'b1;
      if (gnt1 && stat_gnt1 != '1) stat_gnt1 <= stat_gnt1 + 1'b1;
      if (conflict && stat_conflict != '1) stat_conflict <= stat_conflict + 1'b1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
